// File: rtl/dds_pkg.sv
// Types and constants shared by the DDS phase accumulators and the output packer.
package dds_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FLUSH   = 2'd2,
    DRAIN   = 2'd3
  } pack_state_t;

  // Signal types selected by the phase accumulators
  typedef enum logic [1:0] {
    SIG_TONE     = 2'd0,
    SIG_LFM_UP   = 2'd1,
    SIG_LFM_DOWN = 2'd2,
    SIG_LFM_TRI  = 2'd3
  } sig_type_t;

  localparam int unsigned SAMPLE_W_DEFAULT = 12;
  localparam logic [11:0] PAD_CODE_DEFAULT = 12'h800;

  // Index width that stays legal for a single-entry range
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dds_word_fifo.sv
// Synchronous first-word fall-through FIFO; pointers carry one extra wrap bit
// so full and empty are told apart by the MSB.
module dds_word_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  // A write into a full FIFO is accepted only when the head leaves the same cycle
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Head word is masked while empty so stale entries never reach the output
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_wr) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
  end

endmodule

// File: rtl/dds_output_packer.sv
// Packs the sine ROM sample stream of one packet into LANES-wide DAC words,
// buffers them and hands them to the DAC with a valid/ready handshake.
module dds_output_packer
  import dds_pkg::*;
#(
  parameter int unsigned         SAMPLE_W    = SAMPLE_W_DEFAULT,
  parameter int unsigned         LANES       = 4,
  parameter int unsigned         FIFO_DEPTH  = 16,
  parameter int unsigned         ROM_LATENCY = 1,
  parameter logic [SAMPLE_W-1:0] PAD_CODE    = SAMPLE_W'(PAD_CODE_DEFAULT)
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      SIGN_START_CALC,
  input  logic                      SIGN_STOP_CALC,
  input  logic [SAMPLE_W-1:0]       ROM_DATA,
  output logic                      OUT_REG_READY,
  output logic [LANES*SAMPLE_W-1:0] DAC_DATA,
  output logic                      DAC_VALID,
  input  logic                      DAC_READY,
  output logic                      BUSY,
  output logic                      OVERFLOW,
  output logic [15:0]               WORD_COUNT
);

  localparam int unsigned WORD_W = LANES * SAMPLE_W;
  localparam int unsigned IDX_W  = idx_width(LANES);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  pack_state_t state_q;
  pack_state_t state_d;

  logic                   addr_active_q;
  logic [ROM_LATENCY-1:0] vpipe_q;
  logic [ROM_LATENCY-1:0] spipe_q;
  logic [IDX_W-1:0]       idx_q;
  logic [SAMPLE_W-1:0]    lane_q [LANES];
  logic [15:0]            word_count_q;
  logic                   overflow_q;
  logic                   ready_q;
  logic                   busy_q;

  logic                   start_ok_c;
  logic                   push_c;
  logic                   cap_c;
  logic                   dstop_c;
  logic                   pop_c;
  logic                   wr_ok_c;
  logic                   drop_c;
  logic                   ovf_d;
  logic [WORD_W-1:0]      word_c;

  logic [WORD_W-1:0]      fifo_rd_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;

  // Delayed address-valid/stop line up with the ROM output
  assign cap_c   = vpipe_q[ROM_LATENCY-1] && (state_q == CAPTURE);
  assign dstop_c = spipe_q[ROM_LATENCY-1];

  assign pop_c   = !fifo_empty && DAC_READY;
  assign wr_ok_c = push_c && (!fifo_full || pop_c);
  assign drop_c  = push_c && !wr_ok_c;
  assign ovf_d   = start_ok_c ? 1'b0 : (overflow_q || drop_c);

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    start_ok_c = 1'b0;
    push_c     = 1'b0;
    case (state_q)
      IDLE: begin
        // An unresolved overflow keeps the packer closed until reset
        if (SIGN_START_CALC && !overflow_q) begin
          start_ok_c = 1'b1;
          state_d    = CAPTURE;
        end
      end
      CAPTURE: begin
        if (cap_c && (idx_q == LAST_IDX)) push_c = 1'b1;
        if (dstop_c) state_d = FLUSH;
      end
      FLUSH: begin
        push_c  = (idx_q != '0);
        state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_count == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Word under assembly: captured lanes below idx, the live sample at idx, pad above
  always_comb begin
    logic [SAMPLE_W-1:0] lane_v;
    word_c = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_v = (IDX_W'(i) < idx_q) ? lane_q[i] : PAD_CODE;
      if (cap_c && (IDX_W'(i) == idx_q)) lane_v = ROM_DATA;
      word_c[i*SAMPLE_W +: SAMPLE_W] = lane_v;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_active_q <= 1'b0;
      vpipe_q       <= '0;
      spipe_q       <= '0;
      idx_q         <= '0;
      word_count_q  <= '0;
      overflow_q    <= 1'b0;
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      if (start_ok_c)          addr_active_q <= 1'b1;
      else if (SIGN_STOP_CALC) addr_active_q <= 1'b0;

      vpipe_q <= ROM_LATENCY'({vpipe_q, addr_active_q});
      spipe_q <= ROM_LATENCY'({spipe_q, addr_active_q && SIGN_STOP_CALC});

      if (start_ok_c || (state_q == FLUSH)) idx_q <= '0;
      else if (cap_c) idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

      if (start_ok_c) word_count_q <= '0;
      else if (wr_ok_c && (word_count_q != 16'hFFFF)) word_count_q <= word_count_q + 16'd1;

      overflow_q <= ovf_d;
      ready_q    <= (state_d == IDLE) && !ovf_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  always_ff @(posedge CLK) begin
    if (cap_c) lane_q[idx_q] <= ROM_DATA;
  end

  dds_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .wr_en   (push_c),
    .wr_data (word_c),
    .rd_en   (DAC_READY),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign OUT_REG_READY = ready_q;
  assign BUSY          = busy_q;
  assign OVERFLOW      = overflow_q;
  assign WORD_COUNT    = word_count_q;
  assign DAC_VALID     = !fifo_empty;
  assign DAC_DATA      = fifo_rd_data;

endmodule

// File: tb/tb_dds_output_packer.sv
// Scoreboard bench: two packers (ROM latency 1 and 3) share control stimulus,
// each fed by its own ROM model; expected words come from a chunk-and-pad model.
module tb_dds_output_packer;

  localparam int unsigned SW  = 12;
  localparam int unsigned LN  = 4;
  localparam int unsigned WW  = SW * LN;
  localparam logic [SW-1:0] PAD = 12'h800;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic SIGN_START_CALC = 1'b0;
  logic SIGN_STOP_CALC = 1'b0;
  logic DAC_READY = 1'b0;

  logic [SW-1:0] rom1, rom3;
  logic          rdy1, rdy3, valid1, valid3, busy1, busy3, ovf1, ovf3;
  logic [WW-1:0] data1, data3;
  logic [15:0]   wc1, wc3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 1;

  logic [SW-1:0] pkt [$];
  logic          addr_v = 1'b0;
  int            addr = 0;
  logic [SW-1:0] rom_pipe [3];
  logic [WW-1:0] exp1 [$];
  logic [WW-1:0] exp3 [$];
  int            last_pop1, last_pop3, rise1, rise3;

  dds_output_packer #(.ROM_LATENCY(1)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .SIGN_START_CALC(SIGN_START_CALC), .SIGN_STOP_CALC(SIGN_STOP_CALC),
    .ROM_DATA(rom1), .OUT_REG_READY(rdy1), .DAC_DATA(data1), .DAC_VALID(valid1),
    .DAC_READY(DAC_READY), .BUSY(busy1), .OVERFLOW(ovf1), .WORD_COUNT(wc1));

  dds_output_packer #(.ROM_LATENCY(3)) u_dut3 (
    .CLK(CLK), .RESET(RESET), .SIGN_START_CALC(SIGN_START_CALC), .SIGN_STOP_CALC(SIGN_STOP_CALC),
    .ROM_DATA(rom3), .OUT_REG_READY(rdy3), .DAC_DATA(data3), .DAC_VALID(valid3),
    .DAC_READY(DAC_READY), .BUSY(busy3), .OVERFLOW(ovf3), .WORD_COUNT(wc3));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Sine ROM stand-in: packet samples at valid addresses, noise elsewhere
  always @(posedge CLK) begin
    rom_pipe[0] <= addr_v ? pkt[addr] : SW'($urandom);
    rom_pipe[1] <= rom_pipe[0];
    rom_pipe[2] <= rom_pipe[1];
  end
  assign rom1 = rom_pipe[0];
  assign rom3 = rom_pipe[2];

  always @(posedge CLK) begin
    #1;
    case (ready_mode)
      0:       DAC_READY = ($urandom_range(0, 3) != 0);
      1:       DAC_READY = 1'b1;
      default: DAC_READY = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic monitor();
    logic stall1 = 1'b0, stall3 = 1'b0, rdy1_d = 1'b0, rdy3_d = 1'b0;
    logic [WW-1:0] hold1 = '0, hold3 = '0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        stall1 = 1'b0;
        stall3 = 1'b0;
      end else begin
        if (stall1) check("dac_hold_lat1", {15'd0, valid1, data1}, {15'd0, 1'b1, hold1});
        if (stall3) check("dac_hold_lat3", {15'd0, valid3, data3}, {15'd0, 1'b1, hold3});
        if (valid1 && DAC_READY) begin
          if (exp1.size() == 0) begin
            checks++; errors++;
            $display("FAIL dac_word_lat1: got unexpected word 0x%0h, want none", data1);
          end else check("dac_word_lat1", 64'(data1), 64'(exp1.pop_front()));
          last_pop1 = cyc;
        end
        if (valid3 && DAC_READY) begin
          if (exp3.size() == 0) begin
            checks++; errors++;
            $display("FAIL dac_word_lat3: got unexpected word 0x%0h, want none", data3);
          end else check("dac_word_lat3", 64'(data3), 64'(exp3.pop_front()));
          last_pop3 = cyc;
        end
        stall1 = valid1 && !DAC_READY; hold1 = data1;
        stall3 = valid3 && !DAC_READY; hold3 = data3;
        if (rdy1 && !rdy1_d) rise1 = cyc;
        if (rdy3 && !rdy3_d) rise3 = cyc;
        rdy1_d = rdy1;
        rdy3_d = rdy3;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected words: samples in groups of LN, lane 0 earliest, tail padded
  task automatic send_packet(input int n, input int base, input int keep_words, input int abort_at);
    logic [WW-1:0] w;
    int nw;
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back((base >= 0) ? SW'(base + i) : SW'($urandom));
    nw = (n + LN - 1) / LN;
    for (int k = 0; k < nw && k < keep_words; k++) begin
      w = '0;
      for (int l = 0; l < LN; l++) w[l*SW +: SW] = (k*LN + l < n) ? pkt[k*LN + l] : PAD;
      exp1.push_back(w);
      exp3.push_back(w);
    end
    SIGN_START_CALC = 1'b1;
    tick();
    SIGN_START_CALC = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k == abort_at) begin
        check("pre_reset_valid", 64'(valid1), 64'd1);
        check("pre_reset_wc_lat1", 64'(wc1), 64'd3);
        check("pre_reset_wc_lat3", 64'(wc3), 64'd3);
        RESET = 1'b1; addr_v = 1'b0; SIGN_STOP_CALC = 1'b0;
        exp1.delete(); exp3.delete();
        tick();
        RESET = 1'b0;
        check("abort_valid_lat1", 64'(valid1), 64'd0);
        check("abort_valid_lat3", 64'(valid3), 64'd0);
        check("abort_busy_lat1", 64'(busy1), 64'd0);
        check("abort_busy_lat3", 64'(busy3), 64'd0);
        check("abort_ready_lat1", 64'(rdy1), 64'd1);
        check("abort_ready_lat3", 64'(rdy3), 64'd1);
        check("abort_wc_lat1", 64'(wc1), 64'd0);
        check("abort_wc_lat3", 64'(wc3), 64'd0);
        return;
      end
      addr_v = 1'b1;
      addr = k;
      SIGN_STOP_CALC = (k == n - 1);
      tick();
    end
    addr_v = 1'b0;
    SIGN_STOP_CALC = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int want_wc);
    int n = 0;
    while (!(exp1.size() == 0 && exp3.size() == 0 && rdy1 && rdy3) && n < 4000) begin
      tick();
      n++;
    end
    if (n >= 4000) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d/%0d words left, want drained and ready", tag, exp1.size(), exp3.size());
    end
    @(negedge CLK);
    #1;
    check({tag, "_wc_lat1"}, 64'(wc1), 64'(want_wc));
    check({tag, "_wc_lat3"}, 64'(wc3), 64'(want_wc));
    check({tag, "_ovf_lat1"}, 64'(ovf1), 64'd0);
    check({tag, "_ready_delay_lat1"}, 64'(rise1 - last_pop1), 64'd2);
    check({tag, "_ready_delay_lat3"}, 64'(rise3 - last_pop3), 64'd2);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    int n;
    fork monitor(); join_none
    ready_mode = 1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ready", 64'(rdy1), 64'd1);
    check("rst_valid", 64'(valid1), 64'd0);
    check("rst_data", 64'(data1), 64'd0);
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_ovf", 64'(ovf1), 64'd0);
    check("rst_wc", 64'(wc1), 64'd0);
    check("rst_ready_lat3", 64'(rdy3), 64'd1);
    RESET = 1'b0;
    tick();

    send_packet(8, 'h001, 99, -1);
    wait_done("seq8", 2);
    send_packet(6, 'h010, 99, -1);
    wait_done("pad6", 2);

    // Whole 16-word packet held back by the DAC fits the FIFO exactly
    ready_mode = 2;
    tick(); tick();
    send_packet(64, -1, 99, -1);
    repeat (8) tick();
    check("full64_ovf_lat1", 64'(ovf1), 64'd0);
    check("full64_ovf_lat3", 64'(ovf3), 64'd0);
    check("full64_wc_lat1", 64'(wc1), 64'd16);
    check("full64_ready_lat1", 64'(rdy1), 64'd0);
    check("full64_ready_lat3", 64'(rdy3), 64'd0);
    ready_mode = 1;
    wait_done("full64", 16);

    for (int it = 0; it < 10; it++) begin
      ready_mode = 0;
      n = $urandom_range(1, 64);
      send_packet(n, -1, 99, -1);
      wait_done("rand", (n + LN - 1) / LN);
    end

    // 18 words into a 16-deep FIFO with the DAC stalled
    ready_mode = 2;
    tick(); tick();
    send_packet(72, -1, 16, -1);
    repeat (8) tick();
    check("ovf72_ovf_lat1", 64'(ovf1), 64'd1);
    check("ovf72_ovf_lat3", 64'(ovf3), 64'd1);
    check("ovf72_wc_lat1", 64'(wc1), 64'd16);
    check("ovf72_wc_lat3", 64'(wc3), 64'd16);
    ready_mode = 1;
    n = 0;
    while ((exp1.size() != 0 || exp3.size() != 0 || busy1 || busy3) && n < 4000) begin
      tick();
      n++;
    end
    if (n >= 4000) begin
      checks++; errors++;
      $display("FAIL ovf72_drain_timeout: got %0d words left, want 0", exp1.size());
    end
    repeat (4) tick();
    check("ovf72_ready_lat1", 64'(rdy1), 64'd0);
    check("ovf72_ready_lat3", 64'(rdy3), 64'd0);
    SIGN_START_CALC = 1'b1;
    tick();
    SIGN_START_CALC = 1'b0;
    tick();
    check("ovf72_start_ignored", 64'(busy1), 64'd0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("ovf72_reset_ready", 64'(rdy1), 64'd1);
    check("ovf72_reset_ovf", 64'(ovf1), 64'd0);
    tick();

    // Reset mid-capture with three words queued
    ready_mode = 2;
    tick(); tick();
    send_packet(64, -1, 99, 16);
    ready_mode = 1;
    repeat (3) tick();

    send_packet(4, 'h123, 99, -1);
    wait_done("post_abort", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dds_output_packer.md
Name: dds_output_packer

Overview:
- Downstream of the LFM phase accumulator and its sine ROM.
- Captures the ROM sample stream for one packet and packs LANES consecutive samples into one parallel DAC word.
- Buffers packed words in an internal FIFO and presents them to the DAC interface with a valid/ready handshake.
- Drives OUT_REG_READY back to the phase accumulator so a new packet starts only when the packer is idle and empty.

Parameters:
- SAMPLE_W, 12, width of one ROM sample.
- LANES, 4, samples per DAC word.
- FIFO_DEPTH, 16, packed-word FIFO depth; power of 2, at least 2.
- ROM_LATENCY, 1, cycles from a ROM_ADDRESS value to its ROM_DATA; allowed range 1..4.
- PAD_CODE, 12'h800, mid-scale code used to fill an incomplete final word.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- SIGN_START_CALC  in  1  one-cycle pulse from the phase accumulator: packet calculation begins.
- SIGN_STOP_CALC  in  1  high on the cycle the last packet address is driven.
- ROM_DATA  in  SAMPLE_W  sine ROM output.
- OUT_REG_READY  out  1  packer idle, FIFO empty, no overflow pending.
- DAC_DATA  out  LANES*SAMPLE_W  packed word; lane 0 (earliest sample) in the LSBs.
- DAC_VALID  out  1  DAC_DATA valid.
- DAC_READY  in  1  DAC accepts the word when DAC_VALID and DAC_READY are both high.
- BUSY  out  1  state is not IDLE.
- OVERFLOW  out  1  sticky; a packed word was dropped because the FIFO was full.
- WORD_COUNT  out  16  packed words written in the current packet, saturating at 16'hFFFF.

Behaviour:
- Reset values:
  - OUT_REG_READY=1, DAC_VALID=0, DAC_DATA=0, BUSY=0, OVERFLOW=0, WORD_COUNT=0.
  - FIFO empty, lane index 0, latency pipe cleared, state IDLE.
  - RESET mid-packet aborts immediately and discards all FIFO contents.
- addr_valid: high from the cycle after SIGN_START_CALC through the cycle SIGN_STOP_CALC is high, inclusive.
  - addr_valid and a stop marker pass through a ROM_LATENCY-stage shift register.
  - A sample is captured when the delayed addr_valid is high.
- State machine:
  - IDLE: on SIGN_START_CALC go to CAPTURE; clear OVERFLOW, WORD_COUNT and lane index.
  - CAPTURE: each captured sample goes into lane[idx] and idx increments.
    - When idx reaches LANES-1, the completed word is pushed the same cycle and idx wraps to 0.
    - When the delayed stop marker arrives, go to FLUSH.
  - FLUSH (1 cycle): if idx≠0, fill the remaining lanes with PAD_CODE and push the word. Go to DRAIN.
  - DRAIN: wait for the FIFO to empty, then go to IDLE.
- OUT_REG_READY = (state==IDLE) and FIFO empty and not OVERFLOW.
  - OVERFLOW blocks the next start until RESET.
  - SIGN_START_CALC in any non-IDLE state is ignored.
- FIFO:
  - A push while full drops the word, sets OVERFLOW, and does not increment WORD_COUNT.
  - A push and pop in the same cycle while full is allowed; no overflow.
  - First-word fall-through: DAC_VALID rises the cycle after the first push.
  - DAC_DATA is held stable while DAC_VALID=1 and DAC_READY=0.
- Samples are sustained at one per cycle. With DAC_READY constantly high, the FIFO never exceeds 1 word.
- Pointers are log2(FIFO_DEPTH)+1 bits, so full and empty are distinguished by the MSB.
- SIGN_START_CALC and SIGN_STOP_CALC in the same cycle is not legal from upstream; the packer treats START with priority.

Decomposition:
- Shared package dds_pkg holds:
  - the state enum (IDLE, CAPTURE, FLUSH, DRAIN);
  - the default PAD_CODE;
  - the signal-type constants shared with the phase accumulators.
- One sub-module, dds_word_fifo: synchronous FIFO, parameterised width and depth, with first-word fall-through, full, empty and count outputs.

Test Plan:
- 8 samples 0x001..0x008, ROM_LATENCY=1, DAC_READY=1 → two words:
  - 0x004_003_002_001, then 0x008_007_006_005;
  - WORD_COUNT=2; OUT_REG_READY returns to 1 two cycles after the last pop.
- 6 samples 0x010..0x015 → second word is 0x800_800_015_014 (PAD_CODE fill); WORD_COUNT=2.
- DAC_READY=0 for the whole 64-sample packet (16 words) → no OVERFLOW; OUT_REG_READY stays 0 until all 16 words drain after DAC_READY=1.
- DAC_READY=0, 72 samples (18 words) → OVERFLOW=1 at word 17; only 16 words delivered; OUT_REG_READY stays 0 until RESET.
- ROM_LATENCY=3, 4 samples → first word contains exactly the 4 packet samples; no stale or extra lanes.
- RESET asserted during CAPTURE with 3 words in the FIFO → next cycle DAC_VALID=0, BUSY=0, OUT_REG_READY=1, WORD_COUNT=0.
